// File: rtl/neuron_pkg.sv
// Shared types, default widths and arithmetic helpers for the LIF neuron.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package neuron_pkg;

    typedef enum logic {
        ST_INTEG = 1'b0,
        ST_REFR  = 1'b1
    } state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_XW      = 4;
    localparam int DEF_WW      = 4;
    localparam int DEF_MW      = 12;
    localparam int DEF_REFRACT = 3;

    // a + b clamped to the signed range of an mw-bit value (mw <= 30).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int                 mw);
        logic signed [31:0] total;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        total = a + b;
        hi    = (32'sd1 <<< (mw - 1)) - 32'sd1;
        lo    = -(32'sd1 <<< (mw - 1));
        if (total > hi) begin
            sat_add = hi;
        end else if (total < lo) begin
            sat_add = lo;
        end else begin
            sat_add = total;
        end
    endfunction

endpackage

// File: rtl/neuron_wsum.sv
// Synaptic weight register file plus combinational weighted sum of the inputs.
// Latency: weight writes land at the clock edge; sum is combinational from x and stored weights.
// Backpressure: none; writes are always accepted (out-of-range indices are dropped).
//   Ports: clk/rst_n, w_we/w_addr/w_data weight write, x packed unsigned inputs,
//          sum signed sum(w[i] * x[i]) at MW+2 bits.
module neuron_wsum
    import neuron_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int XW = DEF_XW,
    parameter int WW = DEF_WW,
    parameter int MW = DEF_MW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_we,
    input  logic [$clog2(N)-1:0]   w_addr,
    input  logic signed [WW-1:0]   w_data,
    input  logic [N*XW-1:0]        x,
    output logic signed [MW+1:0]   sum
);

    logic signed [WW-1:0] w_q [N];

    // The sum below reads w_q before this edge, so a write coinciding with a
    // beat only affects the following beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                w_q[i] <= '0;
            end
        end else if (w_we && (int'(w_addr) < N)) begin
            w_q[w_addr] <= w_data;
        end
    end

    always_comb begin
        logic signed [MW+1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            // Inputs are unsigned: prepend a zero before treating them as signed.
            acc = acc + (MW+2)'(w_q[i]) * (MW+2)'(signed'({1'b0, x[i*XW +: XW]}));
        end
        sum = acc;
    end

endmodule

// File: rtl/lif_neuron_n.sv
// N-input leaky integrate-and-fire neuron with saturating membrane and refractory period.
// Latency: a beat at edge t shows on membrane/spike from cycle t+1.
// Backpressure: none; beats arriving during refractory are silently dropped.
//   Ports: clk/rst_n, in_valid + x input beat, w_we/w_addr/w_data weight load,
//          threshold/leak_shift config, spike/membrane/refractory status.
//   Optional: ADAPTIVE_THRESH_EN adds a spike-driven threshold offset exposed on th_adj.
module lif_neuron_n
    import neuron_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int XW      = DEF_XW,
    parameter int WW      = DEF_WW,
    parameter int MW      = DEF_MW,
    parameter int REFRACT = DEF_REFRACT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [N*XW-1:0]        x,
    input  logic                   w_we,
    input  logic [$clog2(N)-1:0]   w_addr,
    input  logic signed [WW-1:0]   w_data,
    input  logic signed [MW-1:0]   threshold,
    input  logic [3:0]             leak_shift,
    output logic                   spike,
    output logic [MW-1:0]          membrane,
    output logic                   refractory
`ifdef ADAPTIVE_THRESH_EN
    ,
    output logic [MW-1:0]          th_adj
`endif
);

    localparam int CW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    logic signed [MW+1:0] sum;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [MW-1:0] v_q, v_d, leak;
    logic                 spike_d;
    logic signed [31:0]   v_sum, thr_eff;
    logic                 fire;
`ifdef ADAPTIVE_THRESH_EN
    logic [MW-1:0]        th_q, th_d;
`endif

    neuron_wsum #(.N(N), .XW(XW), .WW(WW), .MW(MW)) u_wsum (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_we   (w_we),
        .w_addr (w_addr),
        .w_data (w_data),
        .x      (x),
        .sum    (sum)
    );

    always_comb begin
        // Kept as an if so the shift stays arithmetic (a ternary with '0 would not be).
        leak = '0;
        if (leak_shift != 4'd0) begin
            leak = v_q >>> leak_shift;
        end
        v_sum = sat_add(32'(v_q) - 32'(leak), 32'(sum), MW);
`ifdef ADAPTIVE_THRESH_EN
        thr_eff = 32'(threshold) + $signed({{(32-MW){1'b0}}, th_q});
`else
        thr_eff = 32'(threshold);
`endif
        fire = (v_sum >= thr_eff);

        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        spike_d = 1'b0;
`ifdef ADAPTIVE_THRESH_EN
        th_d    = th_q;
`endif
        case (state_q)
            ST_INTEG: begin
                if (in_valid) begin
                    if (fire) begin
                        spike_d = 1'b1;
                        v_d     = '0;
                        state_d = ST_REFR;
                        cnt_d   = CW'(REFRACT - 1);
`ifdef ADAPTIVE_THRESH_EN
                        th_d = (th_q > ({MW{1'b1}} - MW'(2))) ? {MW{1'b1}} : th_q + MW'(2);
`endif
                    end else begin
                        v_d = MW'(v_sum);
`ifdef ADAPTIVE_THRESH_EN
                        th_d = (th_q == '0) ? '0 : th_q - MW'(1);
`endif
                    end
                end
            end
            ST_REFR: begin
                v_d = '0;
                if (cnt_q == '0) begin
                    state_d = ST_INTEG;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_INTEG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INTEG;
            cnt_q   <= '0;
            v_q     <= '0;
            spike   <= 1'b0;
`ifdef ADAPTIVE_THRESH_EN
            th_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            spike   <= spike_d;
`ifdef ADAPTIVE_THRESH_EN
            th_q    <= th_d;
`endif
        end
    end

    assign membrane   = v_q;
    assign refractory = (state_q == ST_REFR);
`ifdef ADAPTIVE_THRESH_EN
    assign th_adj     = th_q;
`endif

endmodule

// File: tb/tb_lif_neuron_n.sv
// Self-checking bench for lif_neuron_n: directed scenarios plus randomized traffic
// compared against an integer reference model of the neuron rules.
module tb_lif_neuron_n;

    localparam int N       = 3;
    localparam int XW      = 4;
    localparam int WW      = 4;
    localparam int MW      = 12;
    localparam int REFRACT = 3;
    localparam int AW      = $clog2(N);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  in_valid = 1'b0;
    logic [N*XW-1:0]       x = '0;
    logic                  w_we = 1'b0;
    logic [AW-1:0]         w_addr = '0;
    logic signed [WW-1:0]  w_data = '0;
    logic signed [MW-1:0]  threshold = '0;
    logic [3:0]            leak_shift = '0;
    logic                  spike;
    logic [MW-1:0]         membrane;
    logic                  refractory;
`ifdef ADAPTIVE_THRESH_EN
    logic [MW-1:0]         th_adj;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_v, m_rem, m_th;
    int m_w [N];
    bit m_spike;

    lif_neuron_n #(.N(N), .XW(XW), .WW(WW), .MW(MW), .REFRACT(REFRACT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .x          (x),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .threshold  (threshold),
        .leak_shift (leak_shift),
        .spike      (spike),
        .membrane   (membrane),
        .refractory (refractory)
`ifdef ADAPTIVE_THRESH_EN
        ,
        .th_adj     (th_adj)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_v = 0; m_rem = 0; m_th = 0; m_spike = 0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
    endfunction

    // One clock edge of the neuron rules, using the inputs currently driven.
    function automatic void model_edge();
        int s, lk, vn, thr, ls, hi, lo;
        s = 0;
        for (int i = 0; i < N; i++) s += m_w[i] * int'(x[i*XW +: XW]);
        hi = (1 << (MW - 1)) - 1;
        lo = -(1 << (MW - 1));
        ls = int'(leak_shift);
        m_spike = 0;
        if (m_rem > 0) begin
            m_rem -= 1;
            m_v = 0;
        end else if (in_valid) begin
            lk = (ls == 0) ? 0 : (m_v >>> ls);
            vn = m_v - lk + s;
            if (vn > hi) vn = hi;
            if (vn < lo) vn = lo;
            thr = int'(threshold);
`ifdef ADAPTIVE_THRESH_EN
            thr += m_th;
`endif
            if (vn >= thr) begin
                m_spike = 1;
                m_v = 0;
                m_rem = REFRACT;
                m_th = (m_th + 2 > (1 << MW) - 1) ? (1 << MW) - 1 : m_th + 2;
            end else begin
                m_v = vn;
                m_th = (m_th > 0) ? m_th - 1 : 0;
            end
        end
        if (w_we && int'(w_addr) < N) m_w[w_addr] = int'(w_data);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_x(input int a, input int b, input int c);
        x = {XW'(c), XW'(b), XW'(a)};
    endtask

    task automatic wr(input int addr, input int data);
        w_we = 1'b1; w_addr = AW'(addr); w_data = WW'(data);
        tick();
        w_we = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; w_we = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        in_valid = 1'b1; set_x(15, 15, 15);
        @(negedge clk);
        @(negedge clk);
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL reset_spike got=%b exp=0", spike); end
        checks++; if (membrane !== '0) begin errors++; $display("FAIL reset_membrane got=%0d exp=0", membrane); end
        checks++; if (refractory !== 1'b0) begin errors++; $display("FAIL reset_refractory got=%b exp=0", refractory); end
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_fire_refract();
        int rcount;
        do_reset();
        wr(0, 2); wr(1, 1);
        threshold = 12'sd8; leak_shift = 4'd0;
        set_x(2, 1, 0); in_valid = 1'b1;
        tick();
        checks++; if (membrane !== 12'd5 || spike !== 1'b0) begin errors++; $display("FAIL beat1 membrane=%0d spike=%b exp 5/0", membrane, spike); end
        tick();
        checks++; if (spike !== 1'b1 || membrane !== 12'd0 || refractory !== 1'b1) begin errors++; $display("FAIL fire spike=%b mem=%0d refr=%b exp 1/0/1", spike, membrane, refractory); end
        rcount = 1;
        set_x(4, 3, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (spike !== 1'b0 || membrane !== 12'd0) begin errors++; $display("FAIL refr_hold k=%0d spike=%b mem=%0d exp 0/0", k, spike, membrane); end
            if (refractory === 1'b1) rcount++;
        end
        checks++; if (rcount !== REFRACT) begin errors++; $display("FAIL refr_len got=%0d exp=%0d", rcount, REFRACT); end
        tick();
        checks++; if (spike !== 1'b1 || membrane !== 12'd0) begin errors++; $display("FAIL post_refr_fire spike=%b mem=%0d exp 1/0", spike, membrane); end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (refractory !== 1'b0) begin errors++; $display("FAIL refr_end got=%b exp=0", refractory); end
    endtask

    task automatic test_leak();
        int exp_v [6] = '{8, 12, 14, 15, 16, 16};
        wr(0, 1); wr(1, 0);
        threshold = 12'sd100; leak_shift = 4'd1;
        set_x(8, 0, 0); in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (membrane !== MW'(exp_v[k]) || spike !== 1'b0) begin errors++; $display("FAIL leak k=%0d mem=%0d exp=%0d spike=%b", k, membrane, exp_v[k], spike); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        wr(0, -8);
        threshold = 12'sd100; leak_shift = 4'd0;
        set_x(15, 0, 0); in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (spike !== 1'b0 || membrane[MW-1] !== 1'b1) begin errors++; $display("FAIL sat_sign k=%0d mem=%0d spike=%b", k, membrane, spike); end
        end
        checks++; if (membrane !== 12'h800) begin errors++; $display("FAIL sat_clamp got=%h exp=800", membrane); end
        in_valid = 1'b0;
    endtask

    task automatic test_weight_write();
        do_reset();
        threshold = 12'sd100; leak_shift = 4'd0;
        wr(3, 7);                       // out of range for N=3: dropped
        set_x(1, 1, 1); in_valid = 1'b1;
        wr(0, 1);                       // same cycle as a beat: old w0=0 used
        checks++; if (membrane !== 12'd0) begin errors++; $display("FAIL wr_same_beat got=%0d exp=0", membrane); end
        tick();
        checks++; if (membrane !== 12'd1) begin errors++; $display("FAIL wr_next_beat got=%0d exp=1", membrane); end
        in_valid = 1'b0;
        wr(2, 3);
        set_x(1, 1, 2); in_valid = 1'b1;
        tick();
        checks++; if (membrane !== 12'd8) begin errors++; $display("FAIL wr_lane2 got=%0d exp=8", membrane); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_refr();
        do_reset();
        wr(0, 7);
        threshold = 12'sd8; leak_shift = 4'd0;
        set_x(15, 0, 0); in_valid = 1'b1;
        tick();
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL pre_reset_fire got=%b exp=1", spike); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (spike !== 1'b0 || membrane !== '0 || refractory !== 1'b0) begin errors++; $display("FAIL async_reset spike=%b mem=%0d refr=%b exp 0/0/0", spike, membrane, refractory); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        checks++; if (membrane !== 12'd0 || spike !== 1'b0) begin errors++; $display("FAIL weights_cleared mem=%0d spike=%b exp 0/0", membrane, spike); end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_thresh();
        threshold = 12'sd0; set_x(0, 0, 0); in_valid = 1'b1;
        tick();
        checks++; if (spike !== 1'b1 || membrane !== 12'd0) begin errors++; $display("FAIL thresh_zero spike=%b mem=%0d exp 1/0", spike, membrane); end
        in_valid = 1'b0;
        repeat (3) tick();
        threshold = -12'sd5; in_valid = 1'b1;
        tick();
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL thresh_neg spike=%b exp=1", spike); end
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) begin
                threshold  = MW'(int'($urandom_range(0, 300)) - 60);
                leak_shift = 4'($urandom_range(0, 4));
            end
            in_valid = ($urandom_range(0, 9) < 7);
            x        = (N*XW)'($urandom);
            w_we     = ($urandom_range(0, 3) == 0);
            w_addr   = AW'($urandom_range(0, 3));
            w_data   = WW'($urandom);
            tick();
            checks++; if (spike !== m_spike) begin errors++; $display("FAIL rnd_spike c=%0d got=%b exp=%b", c, spike, m_spike); end
            checks++; if (membrane !== MW'(m_v)) begin errors++; $display("FAIL rnd_membrane c=%0d got=%0d exp=%0d", c, $signed(membrane), m_v); end
            checks++; if (refractory !== (m_rem > 0)) begin errors++; $display("FAIL rnd_refr c=%0d got=%b exp=%b", c, refractory, m_rem > 0); end
`ifdef ADAPTIVE_THRESH_EN
            checks++; if (th_adj !== MW'(m_th)) begin errors++; $display("FAIL rnd_th_adj c=%0d got=%0d exp=%0d", c, th_adj, m_th); end
`endif
        end
        in_valid = 1'b0; w_we = 1'b0;
    endtask

`ifdef ADAPTIVE_THRESH_EN
    task automatic test_adaptive();
        do_reset();
        wr(0, 5);
        threshold = 12'sd4; leak_shift = 4'd0;
        set_x(1, 0, 0); in_valid = 1'b1;
        tick();
        checks++; if (spike !== 1'b1 || th_adj !== 12'd2) begin errors++; $display("FAIL adapt_first spike=%b th=%0d exp 1/2", spike, th_adj); end
        in_valid = 1'b0;
        repeat (3) tick();
        in_valid = 1'b1;
        tick();
        checks++; if (spike !== 1'b0 || membrane !== 12'd5 || th_adj !== 12'd1) begin errors++; $display("FAIL adapt_hold spike=%b mem=%0d th=%0d exp 0/5/1", spike, membrane, th_adj); end
        tick();
        checks++; if (spike !== 1'b1 || th_adj !== 12'd3) begin errors++; $display("FAIL adapt_second spike=%b th=%0d exp 1/3", spike, th_adj); end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fire_refract();
        test_leak();
        test_saturation();
        test_weight_write();
        test_reset_mid_refr();
        test_zero_thresh();
        test_random();
`ifdef ADAPTIVE_THRESH_EN
        test_adaptive();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
